// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester and shared memory port signal bundle
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        stall;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one memory port with wait timeout
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is data-first fixed priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic        grant_i, grant_d, timeout, done;
  logic        m_req_q, m_we_q;
  logic [31:0] m_addr_q, m_wdata_q;
`ifdef MEM_ARB_RR_EN
  logic        last_d;
`endif

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    timeout    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (bus.d_req && (!bus.if_req || !last_d)) grant_d = 1'b1;
        else if (bus.if_req)                       grant_i = 1'b1;
`else
        if (bus.d_req)       grant_d = 1'b1;
        else if (bus.if_req) grant_i = 1'b1;
`endif
        if (grant_d)      state_next = GNT_D;
        else if (grant_i) state_next = GNT_I;
      end
      GNT_I, GNT_D: begin
        // wait_cnt counts completed wait cycles, so this is the TIMEOUT_CYC-th grant cycle
        timeout = (wait_cnt == WAIT_LIMIT);
        done    = bus.m_ack || timeout;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      wait_cnt  <= 16'h0;
`ifdef MEM_ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (grant_d) begin
        m_req_q   <= 1'b1;
        m_we_q    <= bus.d_we;
        m_addr_q  <= bus.d_addr;
        m_wdata_q <= bus.d_wdata;
        wait_cnt  <= 16'h0;
      end else if (grant_i) begin
        m_req_q   <= 1'b1;
        m_we_q    <= 1'b0;
        m_addr_q  <= bus.if_addr;
        m_wdata_q <= 32'h0;
        wait_cnt  <= 16'h0;
      end else if (done) begin
        m_req_q  <= 1'b0;
        wait_cnt <= 16'h0;
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 16'h1;
      end
`ifdef MEM_ARB_RR_EN
      if (grant_d || grant_i) last_d <= grant_d;
`endif
    end
  end

  // Completion is suppressed while reset is asserted, even if the old grant sees m_ack.
  assign bus.if_ack   = !reset && (state == GNT_I) && done;
  assign bus.d_ack    = !reset && (state == GNT_D) && done;
  assign bus.err      = !reset && done && timeout && !bus.m_ack;
  assign bus.if_rdata = (bus.if_ack && bus.m_ack) ? bus.m_rdata : 32'h0;
  assign bus.d_rdata  = (bus.d_ack && bus.m_ack) ? bus.m_rdata : 32'h0;
  assign bus.stall    = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int T = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT_CYC(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  bit          i_pend = 1'b0, d_pend = 1'b0, d_we_v = 1'b0, last_d = 1'b0;
  logic [31:0] i_addr_v = 32'h0, d_addr_v = 32'h0, d_wdata_v = 32'h0;

  task automatic drive_reqs();
    bus.if_req  = i_pend;
    bus.if_addr = i_addr_v;
    bus.d_req   = d_pend;
    bus.d_we    = d_we_v;
    bus.d_addr  = d_addr_v;
    bus.d_wdata = d_wdata_v;
  endtask

  // Entered one time unit after an edge with the arbiter idle; leaves in the same situation.
  task automatic run_txn(input int lat, input logic [31:0] rdata_v);
    bit          win_d, e_we, exp_ack, exp_err, exp_stall, win_ack, oth_ack;
    int          ack_at;
    logic [31:0] e_addr, e_wd, exp_rd, win_rd, oth_rd;
    win_d  = d_pend && (!i_pend || !RR_MODE || !last_d);
    ack_at = (lat < T) ? lat : T - 1;
    e_we   = win_d ? d_we_v : 1'b0;
    e_addr = win_d ? d_addr_v : i_addr_v;
    e_wd   = win_d ? d_wdata_v : 32'h0;
    drive_reqs();
    bus.m_ack   = 1'($urandom_range(0, 1));
    bus.m_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.err !== 1'b0 || bus.m_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got if_ack=%b d_ack=%b err=%b m_req=%b want all 0",
               bus.if_ack, bus.d_ack, bus.err, bus.m_req);
    end
    checks++;
    if (bus.stall !== (i_pend | d_pend)) begin
      errors++;
      $display("FAIL idle_stall got %b want %b", bus.stall, i_pend | d_pend);
    end
    @(posedge clk); #1;
    last_d    = win_d;
    bus.m_ack = 1'b0;
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_we !== e_we || bus.m_addr !== e_addr || bus.m_wdata !== e_wd) begin
      errors++;
      $display("FAIL grant_port got req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
               bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, e_we, e_addr, e_wd);
    end
    for (int g = 0; g <= ack_at; g++) begin
      bus.m_ack   = (g == lat);
      bus.m_rdata = (g == lat) ? rdata_v : $urandom;
      @(negedge clk);
      exp_ack   = (g == ack_at);
      exp_err   = exp_ack && (lat >= T);
      exp_rd    = (exp_ack && lat < T) ? rdata_v : 32'h0;
      exp_stall = win_d ? ((d_pend & !exp_ack) | i_pend) : ((i_pend & !exp_ack) | d_pend);
      win_ack   = win_d ? bus.d_ack : bus.if_ack;
      oth_ack   = win_d ? bus.if_ack : bus.d_ack;
      win_rd    = win_d ? bus.d_rdata : bus.if_rdata;
      oth_rd    = win_d ? bus.if_rdata : bus.d_rdata;
      checks++;
      if (win_ack !== exp_ack || oth_ack !== 1'b0 || bus.err !== exp_err) begin
        errors++;
        $display("FAIL grant_ack cyc=%0d lat=%0d got ack=%b other=%b err=%b want %b 0 %b",
                 g, lat, win_ack, oth_ack, bus.err, exp_ack, exp_err);
      end
      checks++;
      if (win_rd !== exp_rd || oth_rd !== 32'h0) begin
        errors++;
        $display("FAIL grant_rdata cyc=%0d got %h other=%h want %h 0", g, win_rd, oth_rd, exp_rd);
      end
      checks++;
      if (bus.stall !== exp_stall) begin
        errors++;
        $display("FAIL grant_stall cyc=%0d got %b want %b", g, bus.stall, exp_stall);
      end
      @(posedge clk); #1;
    end
    bus.m_ack = 1'b0;
    if (win_d) d_pend = 1'b0;
    else       i_pend = 1'b0;
    drive_reqs();
    checks++;
    if (bus.m_req !== 1'b0) begin
      errors++;
      $display("FAIL release_mreq got %b want 0", bus.m_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_pend = 1'b1; d_pend = 1'b1; i_addr_v = 32'h44; d_addr_v = 32'h88;
    drive_reqs();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.m_req !== 1'b0 || bus.m_we !== 1'b0 || bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_port got req=%b we=%b addr=%h wdata=%h want zeros",
               bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata);
    end
    checks++;
    if (bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0 || bus.err !== 1'b0 ||
        bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp got if_ack=%b d_ack=%b err=%b ird=%h drd=%h want zeros",
               bus.if_ack, bus.d_ack, bus.err, bus.if_rdata, bus.d_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0; i_pend = 1'b0; d_pend = 1'b0; last_d = 1'b0;
    drive_reqs();
    bus.m_ack = 1'b0;
  endtask

  task automatic test_fetch();
    i_pend = 1'b1; i_addr_v = 32'h100;
    run_txn(2, 32'h0050_0093);
  endtask

  task automatic test_data_write();
    d_pend = 1'b1; d_we_v = 1'b1; d_addr_v = 32'h2000; d_wdata_v = 32'hDEAD_BEEF;
    run_txn(1, 32'h0);
  endtask

  task automatic test_tie();
    i_pend = 1'b1; i_addr_v = 32'h300;
    d_pend = 1'b1; d_we_v = 1'b0; d_addr_v = 32'h4000; d_wdata_v = 32'h0;
    run_txn(0, 32'hAAAA_0001);
    d_pend = 1'b1; d_addr_v = 32'h4004;
    run_txn(1, 32'hAAAA_0002);
    run_txn(0, 32'hAAAA_0003);
  endtask

  task automatic test_timeout();
    d_pend = 1'b1; d_we_v = 1'b0; d_addr_v = 32'h5000;
    run_txn(1000, 32'hFFFF_FFFF);
    d_pend = 1'b1; d_addr_v = 32'h5004;
    run_txn(T - 1, 32'h0BAD_F00D);
  endtask

  task automatic test_reset_mid_grant();
    i_pend = 1'b1; i_addr_v = 32'h600;
    drive_reqs();
    @(posedge clk); #1;
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h600) begin
      errors++;
      $display("FAIL midrst_grant got req=%b addr=%h want 1 00000600", bus.m_req, bus.m_addr);
    end
    reset = 1'b1; bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFE_0000;
    @(negedge clk);
    checks++;
    if (bus.if_ack !== 1'b0 || bus.if_rdata !== 32'h0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_resp got ack=%b rdata=%h err=%b want 0 0 0", bus.if_ack, bus.if_rdata, bus.err);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.m_ack = 1'b0; last_d = 1'b0;
    checks++;
    if (bus.m_req !== 1'b0 || bus.m_addr !== 32'h0) begin
      errors++;
      $display("FAIL midrst_port got req=%b addr=%h want 0 0", bus.m_req, bus.m_addr);
    end
    run_txn(0, 32'hCAFE_0001);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1; i_addr_v = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1; d_we_v = 1'($urandom_range(0, 1));
        d_addr_v = $urandom; d_wdata_v = $urandom;
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1'b1; i_addr_v = $urandom;
      end
      run_txn($urandom_range(0, T + 1), $urandom);
    end
    while (i_pend || d_pend) run_txn($urandom_range(0, T - 1), $urandom);
  endtask

  initial begin
    bus.m_ack = 1'b0;
    bus.m_rdata = 32'h0;
    drive_reqs();
    test_reset();
    test_fetch();
    test_data_write();
    test_tie();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max cycles a grant waits for m_ack before abort (1..65535).
REQ-002 clk  input  1  rising-edge clock, only clock of the block.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 if_addr  input  32  fetch byte address, stable while if_req high.
REQ-006 if_rdata  output  32  fetch read data, valid with if_ack.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data-access request, held until d_ack.
REQ-009 d_we  input  1  data write (1) / read (0), stable while d_req high.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  data write value.
REQ-012 d_rdata  output  32  data read value, valid with d_ack.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 m_req  output  1  shared memory port request, registered.
REQ-015 m_we  output  1  shared port write enable, registered.
REQ-016 m_addr  output  32  shared port address, registered.
REQ-017 m_wdata  output  32  shared port write data, registered.
REQ-018 m_rdata  input  32  shared port read data, valid with m_ack.
REQ-019 m_ack  input  1  shared port completion, sampled only while m_req high.
REQ-020 stall  output  1  combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-021 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-022 FSM states IDLE, GNT_I, GNT_D; one transaction in flight at most.
REQ-023 IDLE: d_req -> GNT_D; else if_req -> GNT_I; else stay (fixed priority, data first).
REQ-024 On entry to a grant state, m_req=1 and m_we/m_addr/m_wdata are latched from the granted requester (m_we=0, m_wdata=0 for fetch) in the same edge.
REQ-025 Minimum latency: request seen in IDLE at edge N, m_req high after edge N, ack earliest in cycle N+1 if m_ack returned combinationally.
REQ-026 In grant state, m_ack=1 -> granted ack=1 and granted rdata=m_rdata in that cycle (combinational); next edge m_req=0, state IDLE.
REQ-027 Non-granted ack always 0; non-granted rdata holds 0.
REQ-028 Back-to-back: after completion, IDLE re-arbitrates next cycle; one idle cycle between transactions.
REQ-029 Wait counter, 16 bits, cleared on grant entry, increments each grant cycle without m_ack.
REQ-030 Counter reaching TIMEOUT_CYC with no m_ack -> granted ack=1, rdata=0, err=1 that cycle; next edge IDLE, m_req=0.
REQ-031 m_ack and timeout in same cycle -> normal completion, err=0.
REQ-032 Requests dropped mid-grant are ignored; transaction completes on the port, ack is still pulsed.
REQ-033 m_ack while IDLE is ignored.

Reset
REQ-034 reset high at any edge, including mid-transaction: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, counter=0.
REQ-035 During and after reset until next grant: if_ack=0, d_ack=0, err=0, if_rdata=0, d_rdata=0.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: round-robin; when both requests pending in IDLE, grant the requester not served last (last-served flag resets to fetch, so first tie goes to data).
REQ-037 MEM_ARB_RR_EN undefined: fixed priority per REQ-023, no last-served flag.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x100, m_ack 2 cycles after m_req with m_rdata=0x00500093 -> m_addr=0x100, m_we=0, if_ack one cycle, if_rdata=0x00500093.
REQ-039 Data write: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, m_ack next cycle -> m_we=1, m_wdata=0xDEADBEEF, d_ack one pulse, stall low after ack.
REQ-040 Tie: if_req and d_req both high from same cycle -> GNT_D first; without macro data wins again if re-asserted, with MEM_ARB_RR_EN fetch granted next.
REQ-041 Timeout: TIMEOUT_CYC=4, d_req read, m_ack never -> d_ack=1, d_rdata=0, err=1 on the 4th wait cycle, m_req low next cycle.
REQ-042 Reset mid-grant: reset for one cycle while in GNT_I with m_req=1 -> m_req=0, no if_ack, next request re-arbitrated from IDLE.
